// File: rtl/weight_index_gen_pkg.sv
// weight_pkg: shared state/mode types and default bounds for the weight index generator
package weight_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic {ROW_MAJOR, COL_MAJOR} mode_e;
    localparam int DEF_MAX_ROWS = 8;
    localparam int DEF_MAX_COLS = 8;
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/weight_index_gen_if.sv
// weight_index_gen_if: control and index bus of the weight index generator (cfg_passes with WEIGHT_INDEX_REPEAT_EN)
interface weight_index_gen_if import weight_pkg::*; #(
    parameter int MAX_ROWS = DEF_MAX_ROWS,
    parameter int MAX_COLS = DEF_MAX_COLS
);
    localparam int ROW_W = idx_w(MAX_ROWS);
    localparam int COL_W = idx_w(MAX_COLS);
    localparam int RB = $clog2(MAX_ROWS + 1);
    localparam int CB = $clog2(MAX_COLS + 1);
    logic start, abort, mode, advance;
    logic [RB-1:0] cfg_rows;
    logic [CB-1:0] cfg_cols;
`ifdef WEIGHT_INDEX_REPEAT_EN
    logic [7:0] cfg_passes;
`endif
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic valid, last_inner, last, busy, done;
    modport master (
`ifdef WEIGHT_INDEX_REPEAT_EN
        output cfg_passes,
`endif
        output start, abort, mode, cfg_rows, cfg_cols, advance,
        input row, col, valid, last_inner, last, busy, done
    );
    modport slave (
`ifdef WEIGHT_INDEX_REPEAT_EN
        input cfg_passes,
`endif
        input start, abort, mode, cfg_rows, cfg_cols, advance,
        output row, col, valid, last_inner, last, busy, done
    );
endinterface

// File: rtl/weight_index_gen_wrap_counter.sv
// wrap_counter: counter with runtime bound, clear and enable; wrap flags the bound-1 value
module wrap_counter #(
    parameter int W = 3,
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [BW-1:0] bound,
    output logic [W-1:0]  cnt,
    output logic          wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        wrap = BW'(cnt_q) == bound - BW'(1);
        cnt_d = clr ? '0 : !en ? cnt_q : wrap ? '0 : cnt_q + W'(1);
    end
    always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/weight_index_gen.sv
// weight_index_gen: 2-D row/column-major weight index walker; WEIGHT_INDEX_REPEAT_EN adds multi-pass walks
module weight_index_gen import weight_pkg::*; #(
    parameter int MAX_ROWS = DEF_MAX_ROWS,
    parameter int MAX_COLS = DEF_MAX_COLS
) (
    input logic clk,
    input logic reset,
    weight_index_gen_if.slave bus
);
    localparam int ROW_W = idx_w(MAX_ROWS);
    localparam int COL_W = idx_w(MAX_COLS);
    localparam int RB = $clog2(MAX_ROWS + 1);
    localparam int CB = $clog2(MAX_COLS + 1);
    state_e state_q, state_d;
    mode_e mode_q, mode_d;
    logic [RB-1:0] rows_q, rows_d, rows_c;
    logic [CB-1:0] cols_q, cols_d, cols_c;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic valid, step, fin, clr, row_en, col_en, row_wrap, col_wrap, last_pass;
`ifdef WEIGHT_INDEX_REPEAT_EN
    logic [7:0] passes_q, passes_d, pass_q, pass_d;
    assign last_pass = pass_q == passes_q - 8'd1;
`else
    assign last_pass = 1'b1;
`endif
    assign valid = state_q == RUN;
    assign step = valid && bus.advance && !bus.abort;
    assign fin = row_wrap && col_wrap;
    assign rows_c = bus.cfg_rows > RB'(MAX_ROWS) ? RB'(MAX_ROWS) : bus.cfg_rows;
    assign cols_c = bus.cfg_cols > CB'(MAX_COLS) ? CB'(MAX_COLS) : bus.cfg_cols;
    // Fast counter steps on advance; slow counter steps only when the fast one wraps
    assign row_en = mode_q == ROW_MAJOR ? step && col_wrap : step;
    assign col_en = mode_q == ROW_MAJOR ? step : step && row_wrap;
    wrap_counter #(.W(ROW_W), .BW(RB)) u_row (
        .clk(clk), .reset(reset), .clr(clr), .en(row_en), .bound(rows_q), .cnt(row), .wrap(row_wrap)
    );
    wrap_counter #(.W(COL_W), .BW(CB)) u_col (
        .clk(clk), .reset(reset), .clr(clr), .en(col_en), .bound(cols_q), .cnt(col), .wrap(col_wrap)
    );
    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        rows_d = rows_q;
        cols_d = cols_q;
        clr = 1'b0;
`ifdef WEIGHT_INDEX_REPEAT_EN
        passes_d = passes_q;
        pass_d = pass_q;
`endif
        if (bus.abort) begin
            state_d = IDLE;
            clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    mode_d = mode_e'(bus.mode);
                    rows_d = rows_c;
                    cols_d = cols_c;
                    clr = 1'b1;
                    state_d = (rows_c == '0 || cols_c == '0) ? DONE : RUN;
`ifdef WEIGHT_INDEX_REPEAT_EN
                    passes_d = bus.cfg_passes == 8'd0 ? 8'd1 : bus.cfg_passes;
                    pass_d = 8'd0;
`endif
                end
                RUN: if (step && fin) begin
                    state_d = last_pass ? DONE : RUN;
`ifdef WEIGHT_INDEX_REPEAT_EN
                    pass_d = pass_q + 8'd1;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q <= ROW_MAJOR;
            rows_q <= '0;
            cols_q <= '0;
`ifdef WEIGHT_INDEX_REPEAT_EN
            passes_q <= 8'd1;
            pass_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
`ifdef WEIGHT_INDEX_REPEAT_EN
            passes_q <= passes_d;
            pass_q <= pass_d;
`endif
        end
    end
    assign bus.row = row;
    assign bus.col = col;
    assign bus.valid = valid;
    assign bus.busy = valid;
    assign bus.done = state_q == DONE;
    assign bus.last = valid && fin;
    assign bus.last_inner = valid && (mode_q == ROW_MAJOR ? col_wrap : row_wrap);
endmodule

// File: tb/tb_weight_index_gen.sv
// tb_weight_index_gen: directed table-driven bench plus multi-cycle sequences for weight_index_gen
module tb_weight_index_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    weight_index_gen_if #(.MAX_ROWS(8), .MAX_COLS(8)) bus ();
    weight_index_gen #(.MAX_ROWS(8), .MAX_COLS(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic start, abort, mode, adv;
        int rows, cols;
        logic [10:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [10:0] e(int r, int c, logic v, logic li, logic l, logic b, logic d);
        logic [2:0] rr = 3'(r);
        logic [2:0] cc = 3'(c);
        return {rr, cc, v, li, l, b, d};
    endfunction
    function automatic logic [10:0] got();
        return {bus.row, bus.col, bus.valid, bus.last_inner, bus.last, bus.busy, bus.done};
    endfunction
    function automatic vec_t mk(logic s, logic a, logic m, logic adv, int r, int c, logic [10:0] x);
        vec_t v;
        v.start = s; v.abort = a; v.mode = m; v.adv = adv; v.rows = r; v.cols = c; v.exp = x;
        return v;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(logic s, logic a, logic m, logic adv, int r, int c);
        bus.start = s; bus.abort = a; bus.mode = m; bus.advance = adv;
        bus.cfg_rows = 4'(r); bus.cfg_cols = 4'(c);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, n_valid, n_last, n_done, n_busy;
        drive(0, 0, 0, 0, 0, 0);
`ifdef WEIGHT_INDEX_REPEAT_EN
        bus.cfg_passes = 8'd1;
`endif
        tick(); tick();
        chk("reset_state", 32'(got()), 32'(e(0, 0, 0, 0, 0, 0, 0)));
        reset = 1'b1;
        tick();
        // row-major 2x3 with a stray start, done pulse, start during DONE, abort, zero bound
        vq.push_back(mk(1, 0, 0, 1, 2, 3, e(0, 0, 1, 0, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(0, 1, 1, 0, 0, 1, 0)));
        vq.push_back(mk(1, 0, 1, 1, 1, 1, e(0, 2, 1, 1, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(1, 0, 1, 0, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(1, 1, 1, 0, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(1, 2, 1, 1, 1, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(0, 0, 0, 0, 0, 0, 1)));
        vq.push_back(mk(1, 0, 0, 1, 2, 3, e(0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(mk(1, 0, 0, 1, 2, 3, e(0, 0, 1, 0, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(0, 1, 1, 0, 0, 1, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(0, 2, 1, 1, 0, 1, 0)));
        vq.push_back(mk(1, 1, 0, 1, 2, 3, e(0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(mk(0, 0, 0, 1, 2, 3, e(0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(mk(1, 0, 0, 1, 3, 0, e(0, 0, 0, 0, 0, 0, 1)));
        vq.push_back(mk(0, 0, 0, 1, 3, 0, e(0, 0, 0, 0, 0, 0, 0)));
        vq.push_back(mk(1, 1, 0, 1, 2, 2, e(0, 0, 0, 0, 0, 0, 0)));
        foreach (vq[i]) begin
            drive(vq[i].start, vq[i].abort, vq[i].mode, vq[i].adv, vq[i].rows, vq[i].cols);
            tick();
            chk($sformatf("vec%0d", i), 32'(got()), 32'(vq[i].exp));
        end
        // column-major 2x3, advance low on even RUN cycles: each index held two cycles
        drive(1, 0, 1, 1, 2, 3);
        tick();
        n_busy = 0;
        for (int j = 0; j < 12; j++) begin
            k = j / 2;
            chk($sformatf("colmaj%0d", j), 32'(got()), 32'(e(k % 2, k / 2, 1, k % 2, k == 5, 1, 0)));
            n_busy += int'(bus.busy);
            drive(0, 0, 1, j % 2 == 1, 2, 3);
            tick();
        end
        chk("colmaj_busy_cycles", 32'(n_busy), 32'd12);
        chk("colmaj_done", 32'(got()), 32'(e(0, 0, 0, 0, 0, 0, 1)));
        tick();
        // clamp: 12 rows on an 8-row build walks 8 rows
        drive(1, 0, 0, 1, 12, 1);
        tick();
        drive(0, 0, 0, 1, 12, 1);
        n_valid = 0; n_last = 0; n_done = 0;
        for (int j = 0; j < 40 && n_done == 0; j++) begin
            if (bus.valid) begin
                n_valid++;
                if (bus.last) chk("clamp_last_row", 32'(bus.row), 32'd7);
            end
            n_done += int'(bus.done);
            tick();
        end
        chk("clamp_rows", 32'(n_valid), 32'd8);
        chk("clamp_done", 32'(n_done), 32'd1);
        tick();
        // reset mid-run after 4 indices, then a normal 1x1 walk
        drive(1, 0, 0, 1, 3, 3);
        tick();
        drive(0, 0, 0, 1, 3, 3);
        tick(); tick(); tick();
        chk("pre_reset_idx", 32'(got()), 32'(e(1, 0, 1, 0, 0, 1, 0)));
        reset = 1'b0;
        tick();
        chk("mid_reset", 32'(got()), 32'(e(0, 0, 0, 0, 0, 0, 0)));
        reset = 1'b1;
        drive(1, 0, 0, 1, 1, 1);
        tick();
        chk("post_reset_1x1", 32'(got()), 32'(e(0, 0, 1, 1, 1, 1, 0)));
        drive(0, 0, 0, 1, 1, 1);
        tick();
        chk("post_reset_done", 32'(got()), 32'(e(0, 0, 0, 0, 0, 0, 1)));
        tick();
`ifdef WEIGHT_INDEX_REPEAT_EN
        bus.cfg_passes = 8'd3;
        drive(1, 0, 0, 1, 2, 2);
        tick();
        drive(0, 0, 0, 1, 2, 2);
        n_valid = 0; n_last = 0; n_done = 0;
        for (int j = 0; j < 30 && n_done == 0; j++) begin
            n_valid += int'(bus.valid);
            n_last += int'(bus.last);
            n_done += int'(bus.done);
            if (!bus.valid && n_done == 0) chk("repeat_bubble", 32'(bus.valid), 32'd1);
            tick();
        end
        chk("repeat_valid", 32'(n_valid), 32'd12);
        chk("repeat_last", 32'(n_last), 32'd3);
        chk("repeat_done", 32'(n_done), 32'd1);
        tick();
        chk("repeat_idle", 32'(got()), 32'(e(0, 0, 0, 0, 0, 0, 0)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
